// File: rtl/pump_commander_if.sv
// Command-stream bundle between the pump commander and its environment:
// raw switch/level inputs in, update/command/fault out.
interface pump_commander_if;
  logic       power_sw;
  logic [7:0] level;
  logic       level_valid;
  logic       update;
  logic [1:0] command;
  logic       fault;

  // The commander is the source of the update/command stream.
  modport master (
    input  power_sw,
    input  level,
    input  level_valid,
    output update,
    output command,
    output fault
  );

  modport slave (
    output power_sw,
    output level,
    output level_valid,
    input  update,
    input  command,
    input  fault
  );
endinterface

// File: rtl/pump_commander.sv
// Upstream command generator for pump_fsm: shadows the pump state, fills the
// tank with level hysteresis, enforces min run/rest times and a run timeout.
module pump_commander #(
  parameter int unsigned LOW_MARK  = 64,
  parameter int unsigned HIGH_MARK = 192,
  parameter int unsigned MIN_ON    = 100,
  parameter int unsigned MIN_OFF   = 100,
  parameter int unsigned MAX_ON    = 5000
) (
  input logic               clk,
  input logic               reset,
  pump_commander_if.master  cmd_if
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STANDBY = 3'd1,
    S_PUMPING = 3'd2,
    S_REST    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [1:0] CMD_TURN_OFF   = 2'b00;
  localparam logic [1:0] CMD_TURN_ON    = 2'b01;
  localparam logic [1:0] CMD_STOP_PUMP  = 2'b10;
  localparam logic [1:0] CMD_START_PUMP = 2'b11;

  // Marks are compared at 9 bits so a HIGH_MARK of 256 simply never triggers.
  localparam logic [8:0]  LOW_C     = 9'(LOW_MARK);
  localparam logic [8:0]  HIGH_C    = 9'(HIGH_MARK);
  localparam logic [15:0] MIN_ON_C  = 16'(MIN_ON);
  localparam logic [15:0] MIN_OFF_C = 16'(MIN_OFF);
  localparam logic [15:0] MAX_ON_C  = 16'(MAX_ON);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        sync1_q, sync2_q, pwr_prev_q;
  logic        pwr_rise, pwr_fall;
  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  level_q, level_d;
  logic        level_seen_q, level_seen_d;
  logic        update_q, update_d;
  logic [1:0]  command_q, command_d;
  logic        fault_q, fault_d;
  logic        cmd_issue;
  logic [1:0]  cmd_sel;
  logic        level_low, level_high;

  assign pwr_rise   = sync2_q & ~pwr_prev_q;
  assign pwr_fall   = ~sync2_q & pwr_prev_q;
  assign level_low  = level_seen_q && ({1'b0, level_q} < LOW_C);
  assign level_high = ({1'b0, level_q} >= HIGH_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      pwr_prev_q   <= 1'b0;
      state_q      <= S_OFF;
      timer_q      <= 16'd0;
      level_q      <= 8'd0;
      level_seen_q <= 1'b0;
      update_q     <= 1'b0;
      command_q    <= CMD_TURN_OFF;
      fault_q      <= 1'b0;
    end else begin
      sync1_q      <= cmd_if.power_sw;
      sync2_q      <= sync1_q;
      pwr_prev_q   <= sync2_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      level_q      <= level_d;
      level_seen_q <= level_seen_d;
      update_q     <= update_d;
      command_q    <= command_d;
      fault_q      <= fault_d;
    end
  end

  // Power-off beats every other transition; level stop beats timeout.
  always_comb begin
    state_d   = state_q;
    cmd_issue = 1'b0;
    cmd_sel   = command_q;
    if (state_q != S_OFF && pwr_fall) begin
      state_d   = S_OFF;
      cmd_issue = 1'b1;
      cmd_sel   = CMD_TURN_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          if (pwr_rise) begin
            state_d   = S_STANDBY;
            cmd_issue = 1'b1;
            cmd_sel   = CMD_TURN_ON;
          end
        end
        S_STANDBY: begin
          if (level_low) begin
            state_d   = S_PUMPING;
            cmd_issue = 1'b1;
            cmd_sel   = CMD_START_PUMP;
          end
        end
        S_PUMPING: begin
          if (timer_q >= MIN_ON_C && level_high) begin
            state_d   = S_REST;
            cmd_issue = 1'b1;
            cmd_sel   = CMD_STOP_PUMP;
          end else if (timer_q == MAX_ON_C) begin
            state_d   = S_FAULT;
            cmd_issue = 1'b1;
            cmd_sel   = CMD_STOP_PUMP;
          end
        end
        S_REST: begin
          if (timer_q == MIN_OFF_C) state_d = S_STANDBY;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_OFF;
      endcase
    end
  end

  // Registered outputs follow the decision taken this cycle.
  always_comb begin
    update_d  = cmd_issue;
    command_d = cmd_sel;
    fault_d   = (state_d == S_FAULT);
  end

  // Timer restarts on every state change; the level latch is dropped on OFF entry.
  always_comb begin
    timer_d      = (state_d != state_q) ? 16'd0 : sat_inc(timer_q);
    level_d      = level_q;
    level_seen_d = level_seen_q;
    if (state_d == S_OFF && state_q != S_OFF) begin
      level_d      = 8'd0;
      level_seen_d = 1'b0;
    end else if (cmd_if.level_valid) begin
      level_d      = cmd_if.level;
      level_seen_d = 1'b1;
    end
  end

  assign cmd_if.update  = update_q;
  assign cmd_if.command = command_q;
  assign cmd_if.fault   = fault_q;

endmodule
